// File: rtl/id_pipe_decoder_pkg.sv
// Shared opcode/funct codes, instruction segment positions and common constants
// for the ID stage decoder and its pipeline register.
package id_pipe_decoder_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FUNCT_NOP  = 6'b000000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic        RST_ENABLE    = 1'b0;
  localparam logic        READ_ENABLE   = 1'b1;
  localparam logic        READ_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

endpackage

// File: rtl/id_pipe_decoder_decode_comb.sv
// Pure combinational instruction-to-micro-op decoder; read requests are only
// raised while valid_i is high.
module id_pipe_decoder_decode_comb
  import id_pipe_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SHAMT_WIDTH    = 5
) (
  input  logic                      valid_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_WIDTH-1:0]     data_1_i,
  input  logic [DATA_WIDTH-1:0]     data_2_i,
  output logic                      read_en_1_o,
  output logic [REG_ADDR_WIDTH-1:0] read_addr_1_o,
  output logic                      read_en_2_o,
  output logic [REG_ADDR_WIDTH-1:0] read_addr_2_o,
  output logic [5:0]                funct_o,
  output logic [DATA_WIDTH-1:0]     operand_1_o,
  output logic [DATA_WIDTH-1:0]     operand_2_o,
  output logic [SHAMT_WIDTH-1:0]    shamt_o,
  output logic                      write_en_o,
  output logic [REG_ADDR_WIDTH-1:0] write_addr_o,
  output logic                      mem_read_o
);

  logic [5:0]                opcode;
  logic [15:0]               imm;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     imm_zext;
  logic [DATA_WIDTH-1:0]     imm_sext;
  logic [DATA_WIDTH-1:0]     imm_upper;

  assign opcode = inst_i[OP_MSB:OP_LSB];
  assign imm    = inst_i[IMM_MSB:IMM_LSB];
  assign rs     = REG_ADDR_WIDTH'(inst_i[RS_MSB:RS_LSB]);
  assign rt     = REG_ADDR_WIDTH'(inst_i[RT_MSB:RT_LSB]);
  assign rd     = REG_ADDR_WIDTH'(inst_i[RD_MSB:RD_LSB]);

  always_comb begin
    imm_zext        = '0;
    imm_zext[15:0]  = imm;
    imm_sext        = {{(DATA_WIDTH-16){imm[15]}}, imm};
    imm_upper       = '0;
    imm_upper[31:16] = imm;
  end

  always_comb begin
    read_en_1_o   = READ_DISABLE;
    read_addr_1_o = '0;
    read_en_2_o   = READ_DISABLE;
    read_addr_2_o = '0;
    funct_o       = FUNCT_NOP;
    operand_1_o   = '0;
    operand_2_o   = '0;
    shamt_o       = '0;
    write_en_o    = WRITE_DISABLE;
    write_addr_o  = '0;
    mem_read_o    = 1'b0;

    case (opcode)
      OP_SPECIAL: begin
        read_en_1_o   = READ_ENABLE;
        read_addr_1_o = rs;
        read_en_2_o   = READ_ENABLE;
        read_addr_2_o = rt;
        funct_o       = inst_i[FUNCT_MSB:FUNCT_LSB];
        operand_1_o   = data_1_i;
        operand_2_o   = data_2_i;
        shamt_o       = SHAMT_WIDTH'(inst_i[SHAMT_MSB:SHAMT_LSB]);
        write_en_o    = WRITE_ENABLE;
        write_addr_o  = rd;
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        read_en_1_o   = READ_ENABLE;
        read_addr_1_o = rs;
        funct_o       = (opcode == OP_ORI)  ? FUNCT_OR :
                        (opcode == OP_ANDI) ? FUNCT_AND : FUNCT_XOR;
        operand_1_o   = data_1_i;
        operand_2_o   = imm_zext;
        write_en_o    = WRITE_ENABLE;
        write_addr_o  = rt;
      end
      OP_LUI: begin
        funct_o      = FUNCT_OR;
        operand_2_o  = imm_upper;
        write_en_o   = WRITE_ENABLE;
        write_addr_o = rt;
      end
      OP_ADDIU, OP_LW: begin
        read_en_1_o   = READ_ENABLE;
        read_addr_1_o = rs;
        funct_o       = FUNCT_ADDU;
        operand_1_o   = data_1_i;
        operand_2_o   = imm_sext;
        write_en_o    = WRITE_ENABLE;
        write_addr_o  = rt;
        mem_read_o    = (opcode == OP_LW);
      end
      default: ;
    endcase

    // r0 is hardwired; never schedule a writeback to it
    if (write_addr_o == '0) write_en_o = WRITE_DISABLE;

    if (!valid_i) begin
      read_en_1_o   = READ_DISABLE;
      read_addr_1_o = '0;
      read_en_2_o   = READ_DISABLE;
      read_addr_2_o = '0;
    end
  end

endmodule

// File: rtl/id_pipe_decoder.sv
// ID stage: decode, register-read request, load-use interlock and ID/EX register.
// Optional stall counter output built only when ID_STALL_CNT_EN is defined.
module id_pipe_decoder
  import id_pipe_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SHAMT_WIDTH    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [31:0]               in_inst,
  input  logic [DATA_WIDTH-1:0]     reg_val_mux_data_1,
  input  logic [DATA_WIDTH-1:0]     reg_val_mux_data_2,
  output logic                      reg_read_en_1,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_1,
  output logic                      reg_read_en_2,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [5:0]                funct,
  output logic [DATA_WIDTH-1:0]     operand_1,
  output logic [DATA_WIDTH-1:0]     operand_2,
  output logic [SHAMT_WIDTH-1:0]    shamt,
  output logic                      write_reg_en,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  output logic                      mem_read
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  logic                      dec_valid;
  logic [5:0]                dec_funct;
  logic [DATA_WIDTH-1:0]     dec_op_1;
  logic [DATA_WIDTH-1:0]     dec_op_2;
  logic [SHAMT_WIDTH-1:0]    dec_shamt;
  logic                      dec_we;
  logic [REG_ADDR_WIDTH-1:0] dec_wa;
  logic                      dec_mem_read;

  logic                      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [5:0]                funct_q;
  logic [DATA_WIDTH-1:0]     op_1_q;
  logic [DATA_WIDTH-1:0]     op_2_q;
  logic [SHAMT_WIDTH-1:0]    shamt_q;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] wa_q;
  logic                      mem_read_q;

  logic hazard;
  logic load;

  // Read requests are suppressed while reset is asserted.
  assign dec_valid = in_valid && (rst != RST_ENABLE);

  id_pipe_decoder_decode_comb #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .SHAMT_WIDTH   (SHAMT_WIDTH)
  ) u_decode (
    .valid_i      (dec_valid),
    .inst_i       (in_inst),
    .data_1_i     (reg_val_mux_data_1),
    .data_2_i     (reg_val_mux_data_2),
    .read_en_1_o  (reg_read_en_1),
    .read_addr_1_o(reg_addr_1),
    .read_en_2_o  (reg_read_en_2),
    .read_addr_2_o(reg_addr_2),
    .funct_o      (dec_funct),
    .operand_1_o  (dec_op_1),
    .operand_2_o  (dec_op_2),
    .shamt_o      (dec_shamt),
    .write_en_o   (dec_we),
    .write_addr_o (dec_wa),
    .mem_read_o   (dec_mem_read)
  );

  assign hazard = valid_q && mem_read_q && (wa_q != '0) &&
                  ((reg_read_en_1 && (reg_addr_1 == wa_q)) ||
                   (reg_read_en_2 && (reg_addr_2 == wa_q)));

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign load     = in_valid && in_ready;

  // A stalled hazard with out_ready high drains the register, giving one bubble.
  always_comb begin
    valid_d = 1'b0;
    if (flush)                       valid_d = 1'b0;
    else if (load)                   valid_d = 1'b1;
    else if (valid_q && !out_ready)  valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      funct_q    <= FUNCT_NOP;
      op_1_q     <= '0;
      op_2_q     <= '0;
      shamt_q    <= '0;
      we_q       <= WRITE_DISABLE;
      wa_q       <= '0;
      mem_read_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        addr_q     <= in_addr;
        funct_q    <= dec_funct;
        op_1_q     <= dec_op_1;
        op_2_q     <= dec_op_2;
        shamt_q    <= dec_shamt;
        we_q       <= dec_we;
        wa_q       <= dec_wa;
        mem_read_q <= dec_mem_read;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_addr       = addr_q;
  assign funct          = funct_q;
  assign operand_1      = op_1_q;
  assign operand_2      = op_2_q;
  assign shamt          = shamt_q;
  assign write_reg_en   = we_q;
  assign write_reg_addr = wa_q;
  assign mem_read       = mem_read_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE)                  stall_cnt_q <= ZERO_WORD;
    else if (in_valid && !in_ready && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_pipe_decoder.sv
// Directed self-checking bench for id_pipe_decoder; stall counter checks are
// compiled in only when ID_STALL_CNT_EN is defined.
module tb_id_pipe_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_inst;
  logic [31:0] d1, d2;
  logic        re1, re2;
  logic [4:0]  ra1, ra2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic [4:0]  shamt;
  logic        we;
  logic [4:0]  wa;
  logic        mem_read;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_pipe_decoder dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_addr           (in_addr),
    .in_inst           (in_inst),
    .reg_val_mux_data_1(d1),
    .reg_val_mux_data_2(d2),
    .reg_read_en_1     (re1),
    .reg_addr_1        (ra1),
    .reg_read_en_2     (re2),
    .reg_addr_2        (ra2),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_addr          (out_addr),
    .funct             (funct),
    .operand_1         (op1),
    .operand_2         (op2),
    .shamt             (shamt),
    .write_reg_en      (we),
    .write_reg_addr    (wa),
    .mem_read          (mem_read)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, comb settled after #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] v1, input logic [31:0] v2);
    in_valid = v;
    in_inst  = inst;
    in_addr  = a;
    d1       = v1;
    d2       = v2;
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_addr = '0;
    d1 = '0; d2 = '0; out_ready = 1'b1;
    #1;
    // Read requests stay off under reset even with a valid instruction presented
    present(1'b1, 32'h3401_8000, 32'h100, 32'h1234_0000, 32'h0);
    chk("rst_re1", re1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_funct", funct, 6'h00);
    chk("rst_op2", op2, 0);
    chk("rst_wa", wa, 0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ORI r1, r0, 0x8000
    present(1'b1, 32'h3401_8000, 32'h100, 32'h1234_0000, 32'h0);
    chk("ori_re1", re1, 1);
    chk("ori_re2", re2, 0);
    chk("ori_ready", in_ready, 1);
    tick();
    chk("ori_valid", out_valid, 1);
    chk("ori_op1", op1, 32'h1234_0000);
    chk("ori_op2", op2, 32'h0000_8000);
    chk("ori_funct", funct, 6'h25);
    chk("ori_wa", wa, 1);
    chk("ori_we", we, 1);
    chk("ori_addr", out_addr, 32'h100);

    // ADDIU r2, r0, -1
    present(1'b1, 32'h2402_FFFF, 32'h104, 32'h0000_0005, 32'h0);
    tick();
    chk("addiu_op1", op1, 32'h5);
    chk("addiu_op2", op2, 32'hFFFF_FFFF);
    chk("addiu_funct", funct, 6'h21);
    chk("addiu_wa", wa, 2);

    // LUI r5, 0xABCD
    present(1'b1, 32'h3C05_ABCD, 32'h108, 32'hDEAD_BEEF, 32'h0);
    chk("lui_re1", re1, 0);
    chk("lui_re2", re2, 0);
    tick();
    chk("lui_op1", op1, 0);
    chk("lui_op2", op2, 32'hABCD_0000);
    chk("lui_wa", wa, 5);

    // LW r3, 0(r0) followed by dependent OR r4, r3, r1
    present(1'b1, 32'h8C03_0000, 32'h10C, 32'h0000_2000, 32'h0);
    tick();
    chk("lw_mem_read", mem_read, 1);
    chk("lw_wa", wa, 3);
    present(1'b1, 32'h0061_2025, 32'h110, 32'h0000_00F0, 32'h0000_000F);
    chk("lu_ra1", ra1, 3);
    chk("lu_ra2", ra2, 1);
    chk("lu_ready", in_ready, 0);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_ready2", in_ready, 1);
    tick();
    chk("or_valid", out_valid, 1);
    chk("or_wa", wa, 4);
    chk("or_funct", funct, 6'h25);
    chk("or_op1", op1, 32'hF0);
    chk("or_op2", op2, 32'h0F);
    chk("or_mem_read", mem_read, 0);

    // Backpressure: ANDI r6, r5, 0xFF held off for 3 cycles
    out_ready = 1'b0;
    present(1'b1, 32'h30A6_00FF, 32'h114, 32'h0000_0F0F, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_wa", wa, 4);
      chk("bp_addr", out_addr, 32'h110);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", in_ready, 1);
    tick();
    chk("andi_funct", funct, 6'h24);
    chk("andi_op2", op2, 32'hFF);
    chk("andi_wa", wa, 6);
    // XORI r7, r7, 0x1234 back-to-back
    present(1'b1, 32'h38E7_1234, 32'h118, 32'h1, 32'h0);
    chk("xori_ready", in_ready, 1);
    tick();
    chk("xori_funct", funct, 6'h26);
    chk("xori_op2", op2, 32'h1234);
    chk("xori_wa", wa, 7);

    // Destination r0 disables writeback
    present(1'b1, 32'h3400_0001, 32'h11C, 32'h0, 32'h0);
    tick();
    chk("r0_we", we, 0);
    chk("r0_valid", out_valid, 1);

    // SPECIAL with shamt=5, rd=11
    present(1'b1, 32'h000A_5940, 32'h120, 32'h0, 32'h0000_0003);
    chk("sp_re2", re2, 1);
    chk("sp_ra2", ra2, 10);
    tick();
    chk("sp_shamt", shamt, 5);
    chk("sp_wa", wa, 11);
    chk("sp_funct", funct, 6'h00);

    // Unknown opcode still issues as a NOP
    present(1'b1, 32'hFC00_0000, 32'h124, 32'h0, 32'h0);
    chk("unk_re1", re1, 0);
    tick();
    chk("unk_valid", out_valid, 1);
    chk("unk_we", we, 0);
    chk("unk_shamt", shamt, 0);

    // Flush kills the held micro-op and the one presented
    flush = 1'b1;
    present(1'b1, 32'h3408_0055, 32'h128, 32'h0, 32'h0);
    chk("fl_ready", in_ready, 0);
    tick();
    chk("fl_valid", out_valid, 0);
    flush = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl_not_taken", out_valid, 0);
    chk("fl_addr", out_addr, 32'h124);

`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 4);
`endif

    // Asynchronous reset mid-stream
    present(1'b1, 32'h3401_8000, 32'h12C, 32'h7, 32'h0);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_op1", op1, 0);
    chk("arst_wa", wa, 0);
`ifdef ID_STALL_CNT_EN
    chk("arst_stall", stall_cnt, 0);
`endif
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    present(1'b1, 32'h2409_0010, 32'h200, 32'h1, 32'h0);
    tick();
    chk("post_valid", out_valid, 1);
    chk("post_op2", op2, 32'h10);
    chk("post_wa", wa, 9);
    chk("post_addr", out_addr, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_pipe_decoder.md
Name: id_pipe_decoder

Overview:
Next-generation ID stage. It decodes a MIPS instruction, drives the register-read request, and captures the decoded micro-op into an internal ID/EX pipeline register with valid/ready handshakes on both sides. It adds widened opcode coverage (ORI/ANDI/XORI/LUI/ADDIU/LW/SPECIAL), load-use interlock, flush, and backpressure. It sits between IF and EX; operand values arrive from RegReadProxy in the same cycle as the read request.

Parameters:
DATA_WIDTH, 32, operand/immediate-extension width (>=32)
ADDR_WIDTH, 32, instruction address width
REG_ADDR_WIDTH, 5, register index width
SHAMT_WIDTH, 5, shift-amount width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  kill instruction in output register and the one presented this cycle
in_valid  in  1  IF presents instruction
in_ready  out  1  ID accepts instruction this cycle
in_addr  in  ADDR_WIDTH  instruction address
in_inst  in  32  instruction word
reg_val_mux_data_1  in  DATA_WIDTH  forwarded value for reg_addr_1
reg_val_mux_data_2  in  DATA_WIDTH  forwarded value for reg_addr_2
reg_read_en_1 / reg_addr_1  out  1 / REG_ADDR_WIDTH  read port 1 request (comb)
reg_read_en_2 / reg_addr_2  out  1 / REG_ADDR_WIDTH  read port 2 request (comb)
out_valid  out  1  output register holds a valid micro-op
out_ready  in  1  EX accepts
out_addr  out  ADDR_WIDTH  registered instruction address
funct  out  6  EX operation
operand_1 / operand_2  out  DATA_WIDTH  registered operands
shamt  out  SHAMT_WIDTH  registered shift amount
write_reg_en / write_reg_addr  out  1 / REG_ADDR_WIDTH  registered writeback
mem_read  out  1  micro-op is a load
stall_cnt  out  32  load-use stall cycles (only with ID_STALL_CNT_EN)

Behaviour:
- Reset (rst=0, async): out_valid, write_reg_en, mem_read=0; all data outputs, write_reg_addr, funct=FUNCT_NOP, stall_cnt=0. Read requests are combinationally disabled, addr 0.
- Read request (comb from in_inst, gated by in_valid): SPECIAL reads rs, rt; I-type ALU/LW read rs only; LUI reads none; other opcodes read none (disable, addr 0).
- Decode: SPECIAL -> funct=inst funct, op1=rs, op2=rt, dest rd, shamt=inst shamt. ORI/ANDI/XORI -> FUNCT_OR/AND/XOR, op2 zero-extended imm, dest rt. LUI -> FUNCT_OR, op1=0, op2={imm,16'b0} zero-extended to DATA_WIDTH, dest rt. ADDIU -> FUNCT_ADDU, op2 sign-extended imm. LW -> FUNCT_ADDU, sign-extended imm, dest rt, mem_read=1. Unknown opcode -> FUNCT_NOP, write disabled, still valid. Non-SPECIAL shamt=0. Dest 0 forces write_reg_en=0.
- Handshake: load = in_valid && in_ready. in_ready = !hazard && (!out_valid || out_ready). Latency 1 cycle. Output register is held stable while out_valid && !out_ready.
- Load-use hazard: out_valid && mem_read && write_reg_addr!=0 && a read port is enabled with matching addr. Then in_ready=0. If out_ready=1, the register loads a bubble (out_valid<=0). This inserts exactly one bubble; the dependent instruction issues the next cycle.
- Flush: out_valid<=0 and in_ready forced 0 that cycle. Flush has priority over load and hold.
- Simultaneous out_ready with new load: replacement occurs in the same cycle (full throughput, no bubble).

Optional Feature:
ID_STALL_CNT_EN: when defined, stall_cnt increments (wrapping at 2^32) every cycle in_valid && !in_ready && !flush. When undefined, the port is absent and no counter is built.

Decomposition:
- Shared package/defines: OP_* and FUNCT_* codes, segment positions, RST_ENABLE=1'b0, READ/WRITE enables, ZERO_WORD.
- Sub-module id_decode_comb: pure combinational inst-to-micro-op decoder.
- id_pipe_decoder: handshake, hazard logic, and register.

Test Plan:
- ORI 0x34018000 with mux_data_1=0x12340000, out_ready=1 -> next cycle op2=0x00008000, op1=0x12340000, funct=FUNCT_OR, dest 1, out_valid=1.
- ADDIU 0x2402FFFF -> op2=0xFFFFFFFF, funct=FUNCT_ADDU, dest 2. LUI 0x3C05ABCD -> op2=0xABCD0000, op1=0, no read enables.
- LW 0x8C030000 then OR 0x00612025 -> in_ready=0 one cycle, out_valid=0 one cycle, then OR issues with rd=4. stall_cnt=1 if ID_STALL_CNT_EN.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0. Release -> one transfer per cycle.
- flush while out_valid=1 -> out_valid=0 next cycle, the instruction presented that cycle is not accepted.
- rst low mid-stream -> outputs cleared immediately (async); first instruction after release issues normally.
